// File: rtl/l2_cache.sv
// l2_cache: two-way set-associative, write-through, no-write-allocate second-level cache.
// Serves one L1 request at a time; misses and stores go to memory over a req/ready handshake.
module l2_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 4,
    parameter int NUM_SETS   = 1024,
    parameter int NUM_WAYS   = 2,
    parameter int TAG_WIDTH  = ADDR_WIDTH - $clog2(NUM_SETS) - $clog2(BLOCK_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_wr_en_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] req_byte_en_i,
    output logic                    l2_cache_valid_o,
    output logic [DATA_WIDTH-1:0]   l2_cache_data_o,
    output logic                    mem_req_o,
    output logic                    mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wr_data_o,
    output logic [DATA_WIDTH/8-1:0] mem_byte_en_o,
    input  logic                    mem_ready_i,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data_i
);

    localparam int OFFS   = $clog2(BLOCK_SIZE);
    localparam int IDXW   = $clog2(NUM_SETS);
    localparam int WAW    = ADDR_WIDTH - OFFS;
    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_RD,
        S_MEM_WR,
        S_RESP
    } state_t;

    state_t                  r_state;
    logic                    r_req_ready;
    logic                    r_resp_valid;
    logic [DATA_WIDTH-1:0]   r_resp_data;
    logic                    r_mem_req;
    logic                    r_mem_wr_en;
    logic [WAW-1:0]          r_waddr;
    logic                    r_wr_en;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [NBYTES-1:0]       r_be;

    logic [TAG_WIDTH-1:0]    r_tag   [NUM_WAYS][NUM_SETS];
    logic [DATA_WIDTH-1:0]   r_data  [NUM_WAYS][NUM_SETS];
    logic                    r_valid [NUM_WAYS][NUM_SETS];
    logic                    r_lru   [NUM_SETS];   // way to evict next

    logic [IDXW-1:0]         w_idx;
    logic [TAG_WIDTH-1:0]    w_tag;
    logic                    w_hit0;
    logic                    w_hit1;
    logic                    w_hit;
    logic                    w_hit_way;
    logic [DATA_WIDTH-1:0]   w_hit_data;
    logic                    w_victim;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic                    w_arr_we;
    logic                    w_arr_way;
    logic [DATA_WIDTH-1:0]   w_arr_data;
    logic                    w_unused;

    assign w_unused   = ^req_addr_i[OFFS-1:0];

    assign w_idx      = r_waddr[IDXW-1:0];
    assign w_tag      = r_waddr[WAW-1:IDXW];
    assign w_hit0     = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1     = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit      = w_hit0 | w_hit1;
    assign w_hit_way  = w_hit1;
    assign w_hit_data = w_hit1 ? r_data[1][w_idx] : r_data[0][w_idx];
    assign w_victim   = !r_valid[0][w_idx] ? 1'b0 :
                        !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];

    // NOTE: every always_comb output gets a full default first so no path can infer a latch.
    always_comb begin
        w_merged = w_hit_data;
        for (int b = 0; b < NBYTES; b++) begin
            if (r_be[b]) w_merged[b*8 +: 8] = r_wdata[b*8 +: 8];
        end
    end

    // Arrays change on a store hit in LOOKUP or a refill in MEM_RD, never while reset is held.
    assign w_arr_we   = rst && (((r_state == S_LOOKUP) && r_wr_en && w_hit) ||
                                ((r_state == S_MEM_RD) && mem_ready_i));
    assign w_arr_way  = (r_state == S_MEM_RD) ? w_victim : w_hit_way;
    assign w_arr_data = (r_state == S_MEM_RD) ? mem_rd_data_i : w_merged;

    // NOTE: tag/data storage is not reset; the valid bits gate every use, so only they are cleared.
    always_ff @(posedge clk) begin
        if (w_arr_we) begin
            r_tag[w_arr_way][w_idx]  <= w_tag;
            r_data[w_arr_way][w_idx] <= w_arr_data;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_mem_req    <= 1'b0;
            r_mem_wr_en  <= 1'b0;
            r_waddr      <= '0;
            r_wr_en      <= 1'b0;
            r_wdata      <= '0;
            r_be         <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_lru[s] <= 1'b0;
                for (int w = 0; w < NUM_WAYS; w++) r_valid[w][s] <= 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_waddr     <= req_addr_i[ADDR_WIDTH-1:OFFS];
                        r_wr_en     <= req_wr_en_i;
                        r_wdata     <= req_wr_data_i;
                        r_be        <= req_byte_en_i;
                        r_req_ready <= 1'b0;
                        r_state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) r_lru[w_idx] <= ~w_hit_way;
                    if (r_wr_en) begin
                        r_mem_req   <= 1'b1;
                        r_mem_wr_en <= 1'b1;
                        r_state     <= S_MEM_WR;
                    end else if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= w_hit_data;
                        r_state      <= S_RESP;
                    end else begin
                        r_mem_req   <= 1'b1;
                        r_mem_wr_en <= 1'b0;
                        r_state     <= S_MEM_RD;
                    end
                end
                S_MEM_RD: begin
                    if (mem_ready_i) begin
                        r_valid[w_victim][w_idx] <= 1'b1;
                        r_lru[w_idx]             <= ~w_victim;
                        r_mem_req                <= 1'b0;
                        r_resp_valid             <= 1'b1;
                        r_resp_data              <= mem_rd_data_i;
                        r_state                  <= S_RESP;
                    end
                end
                S_MEM_WR: begin
                    if (mem_ready_i) begin
                        r_mem_req   <= 1'b0;
                        r_mem_wr_en <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_data  <= '0;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o      = r_req_ready;
    assign l2_cache_valid_o = r_resp_valid;
    assign l2_cache_data_o  = r_resp_data;
    assign mem_req_o        = r_mem_req;
    assign mem_wr_en_o      = r_mem_wr_en;
    assign mem_addr_o       = {r_waddr, {OFFS{1'b0}}};
    assign mem_wr_data_o    = r_wdata;
    assign mem_byte_en_o    = r_be;

endmodule
